// File: rtl/lfsr_stream_pkg.sv
// Shared definitions for the multi-lane LFSR stream generator:
// feedback tap masks for each legal lane width, the sequencer state
// type and the lane-width legality check.
package lfsr_stream_pkg;

  // Tap positions are 1-based in the polynomial; bit t-1 of the lane
  // state feeds the XOR for tap t.
  localparam logic [127:0] TAPS_32  = (128'd1 << 31) | (128'd1 << 21) |
                                      (128'd1 << 1)  | (128'd1 << 0);
  localparam logic [127:0] TAPS_64  = (128'd1 << 63) | (128'd1 << 62) |
                                      (128'd1 << 60) | (128'd1 << 59);
  localparam logic [127:0] TAPS_128 = (128'd1 << 127) | (128'd1 << 125) |
                                      (128'd1 << 100) | (128'd1 << 98);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit lane_width_legal(input int unsigned width);
    return (width == 32) || (width == 64) || (width == 128);
  endfunction

  function automatic logic [127:0] tap_mask(input int unsigned width);
    logic [127:0] mask;
    case (width)
      32:      mask = TAPS_32;
      64:      mask = TAPS_64;
      128:     mask = TAPS_128;
      default: mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr_lane.sv
// One Fibonacci LFSR lane: state register, XOR feedback, run-time seed
// load with zero-seed substitution and, when LFSR_STREAM_LOOP_DET_EN is
// defined, a reference register that flags when the sequence wraps.
module lfsr_lane
  import lfsr_stream_pkg::*;
#(
  parameter int unsigned LANE_WIDTH = 128,
  parameter logic [LANE_WIDTH-1:0] RESET_VALUE = LANE_WIDTH'(1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seed_load,
  input  logic [LANE_WIDTH-1:0] seed,
  input  logic                  step,
  output logic [LANE_WIDTH-1:0] state,
  output logic                  loop
);

  localparam logic [127:0]            FULL_MASK = tap_mask(LANE_WIDTH);
  localparam logic [LANE_WIDTH-1:0]   TAP_MASK  = FULL_MASK[LANE_WIDTH-1:0];

  logic [LANE_WIDTH-1:0] state_q;
  logic [LANE_WIDTH-1:0] next_state;
  logic [LANE_WIDTH-1:0] seed_value;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  assign next_state = {state_q[LANE_WIDTH-2:0], ^(state_q & TAP_MASK)};
  assign seed_value = (seed == '0) ? LANE_WIDTH'(1) : seed;
  assign state      = state_q;

  // Lane state: a seed load wins, otherwise advance one step per accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_VALUE;
    end else if (seed_load) begin
      state_q <= seed_value;
    end else if (step) begin
      state_q <= next_state;
    end
  end

`ifdef LFSR_STREAM_LOOP_DET_EN
  logic [LANE_WIDTH-1:0] ref_q;
  logic                  loop_q;

  // Remember the starting point and pulse once a step lands back on it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q  <= RESET_VALUE;
      loop_q <= 1'b0;
    end else begin
      loop_q <= 1'b0;
      if (seed_load) begin
        ref_q <= seed_value;
      end else if (step) begin
        loop_q <= (next_state == ref_q);
      end
    end
  end

  assign loop = loop_q;
`else
  assign loop = 1'b0;
`endif

endmodule

// File: rtl/lfsr_stream_gen.sv
// Multi-lane pseudo-random stream source. LANE_NUM independent LFSR
// lanes are concatenated onto a valid/ready stream; bursts are started,
// stopped and sized by the matching controller. Define
// LFSR_STREAM_LOOP_DET_EN to build per-lane sequence-wrap detection on
// o_lfsr_loop; otherwise that output is tied low.
module lfsr_stream_gen
  import lfsr_stream_pkg::*;
#(
  parameter int unsigned LANE_NUM    = 4,
  parameter int unsigned LANE_WIDTH  = 128,
  parameter int unsigned BURST_WIDTH = 16
) (
  input  logic                           i_fclk,
  input  logic                           i_reset,
  input  logic                           i_seed_load,
  input  logic [LANE_NUM*LANE_WIDTH-1:0] i_seed_data,
  input  logic                           i_start,
  input  logic [BURST_WIDTH-1:0]         i_burst_len,
  input  logic                           i_stop,
  input  logic                           i_ready,
  output logic [LANE_NUM*LANE_WIDTH-1:0] o_stream,
  output logic                           o_valid,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [LANE_NUM-1:0]            o_lfsr_loop
);

  generate
    if (!lane_width_legal(LANE_WIDTH)) begin : g_width_check
      $error("lfsr_stream_gen: LANE_WIDTH must be 32, 64 or 128");
    end
  endgenerate

  state_t                 state_q;
  logic [BURST_WIDTH-1:0] beat_count_q;
  logic [BURST_WIDTH-1:0] burst_len_q;
  logic                   accept;
  logic                   seed_load_en;
  logic                   last_beat;

  // Seeds are only taken while idle; a zero burst length never matches
  // the last-beat test, which is what makes it free-running.
  assign accept       = o_valid & i_ready;
  assign seed_load_en = (state_q == IDLE) & i_seed_load;
  assign last_beat    = (burst_len_q != '0) &&
                        (beat_count_q == burst_len_q - BURST_WIDTH'(1));

  // Burst sequencer with registered valid/busy/done and the beat counter.
  always_ff @(posedge i_fclk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      o_valid      <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      beat_count_q <= '0;
      burst_len_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          o_done <= 1'b0;
          if (!i_seed_load && i_start) begin
            state_q      <= RUN;
            o_valid      <= 1'b1;
            o_busy       <= 1'b1;
            beat_count_q <= '0;
            burst_len_q  <= i_burst_len;
          end
        end
        RUN: begin
          if (accept) begin
            beat_count_q <= beat_count_q + BURST_WIDTH'(1);
          end
          if (i_stop || (accept && last_beat)) begin
            state_q <= DONE;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
          end
        end
        DONE: begin
          o_done  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

  // Lane k resets to k+1 so every lane starts on a distinct sequence point.
  for (genvar k = 0; k < LANE_NUM; k++) begin : g_lane
    lfsr_lane #(
      .LANE_WIDTH  (LANE_WIDTH),
      .RESET_VALUE (LANE_WIDTH'(k + 1))
    ) u_lane (
      .clk       (i_fclk),
      .rst       (i_reset),
      .seed_load (seed_load_en),
      .seed      (i_seed_data[k*LANE_WIDTH +: LANE_WIDTH]),
      .step      (accept),
      .state     (o_stream[k*LANE_WIDTH +: LANE_WIDTH]),
      .loop      (o_lfsr_loop[k])
    );
  end

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// Scoreboard bench for lfsr_stream_gen: four 32-bit lanes and a 4-bit
// beat counter so free-running bursts cross the counter wrap.
module tb_lfsr_stream_gen;

  localparam int LN = 4;
  localparam int LW = 32;
  localparam int BW = 4;
  localparam int SW = LN * LW;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_seed_load;
  logic [SW-1:0] i_seed_data;
  logic          i_start;
  logic [BW-1:0] i_burst_len;
  logic          i_stop;
  logic          i_ready;
  logic [SW-1:0] o_stream;
  logic          o_valid;
  logic          o_busy;
  logic          o_done;
  logic [LN-1:0] o_lfsr_loop;

  always #5 clk = ~clk;

  lfsr_stream_gen #(
    .LANE_NUM    (LN),
    .LANE_WIDTH  (LW),
    .BURST_WIDTH (BW)
  ) dut (
    .i_fclk      (clk),
    .i_reset     (rst),
    .i_seed_load (i_seed_load),
    .i_seed_data (i_seed_data),
    .i_start     (i_start),
    .i_burst_len (i_burst_len),
    .i_stop      (i_stop),
    .i_ready     (i_ready),
    .o_stream    (o_stream),
    .o_valid     (o_valid),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_lfsr_loop (o_lfsr_loop)
  );

  int            vectors     = 0;
  int            miscompares = 0;
  logic [SW-1:0] exp_q[$];
  int            done_q[$];
  int            mon_beats   = 0;
  logic [LW-1:0] model_lane[LN];
  int            taps[4]     = '{32, 22, 2, 1};

  // Reference step: shift left, feed back the XOR of the tapped bits.
  function automatic logic [LW-1:0] lfsr_next(input logic [LW-1:0] s);
    logic fb;
    fb = 1'b0;
    foreach (taps[i]) fb ^= s[taps[i]-1];
    return {s[LW-2:0], fb};
  endfunction

  function automatic logic [SW-1:0] model_stream();
    logic [SW-1:0] r;
    r = '0;
    for (int k = 0; k < LN; k++) r[k*LW +: LW] = model_lane[k];
    return r;
  endfunction

  function automatic logic [SW-1:0] reset_stream();
    logic [SW-1:0] r;
    r = '0;
    for (int k = 0; k < LN; k++) r[k*LW +: LW] = LW'(k + 1);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [SW-1:0] actual,
                             input logic [SW-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic failNote(input string name, input string what);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s %s", name, what);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    for (int k = 0; k < LN; k++) model_lane[k] = LW'(k + 1);
  endtask

  task automatic modelLoad(input logic [SW-1:0] seeds);
    for (int k = 0; k < LN; k++)
      model_lane[k] = (seeds[k*LW +: LW] == '0) ? LW'(1) : seeds[k*LW +: LW];
  endtask

  task automatic loadSeeds(input logic [SW-1:0] seeds, input bit with_start);
    i_seed_data = seeds;
    i_seed_load = 1'b1;
    i_start     = with_start;
    i_burst_len = BW'($urandom_range(1, 15));
    tick();
    i_seed_load = 1'b0;
    i_start     = 1'b0;
    modelLoad(seeds);
    checkOutput("seed_load_stream", o_stream, model_stream());
    checkOutput("seed_load_no_valid", o_valid, 0);
  endtask

  task automatic resetMidBurst();
    i_ready = 1'b0;
    i_stop  = 1'b0;
    rst     = 1'b1;
    #2;
    checkOutput("async_reset_valid", o_valid, 0);
    checkOutput("async_reset_busy", o_busy, 0);
    checkOutput("async_reset_done", o_done, 0);
    checkOutput("async_reset_stream", o_stream, reset_stream());
    modelReset();
    exp_q.delete();
    mon_beats = 0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    tick();
  endtask

  // One burst: len beats (0 = free run), optional stop after stop_after
  // accepts, optional asynchronous reset after abort_after accepts.
  task automatic applyStimulus(input int len, input int stop_after,
                               input int stop_rdy, input int abort_after,
                               input bit always_rdy, input bit noise);
    int beats;
    bit finished;
    bit rdy;
    bit stp;
    beats    = 0;
    finished = 1'b0;
    i_burst_len = BW'(len);
    i_start     = 1'b1;
    tick();
    i_start     = 1'b0;
    i_burst_len = BW'($urandom);
    checkOutput("start_valid", o_valid, 1);
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      if (abort_after >= 0 && beats == abort_after) begin
        resetMidBurst();
        return;
      end
      rdy = always_rdy ? 1'b1 : ($urandom_range(0, 3) != 0);
      stp = 1'b0;
      if (stop_after >= 0 && beats == stop_after) begin
        stp = 1'b1;
        if (stop_rdy >= 0) rdy = (stop_rdy != 0);
      end
      i_ready = rdy;
      i_stop  = stp;
      if (noise) begin
        i_seed_load = ($urandom_range(0, 3) == 0);
        i_seed_data = {$urandom, $urandom, $urandom, $urandom};
        i_start     = ($urandom_range(0, 3) == 0);
      end
      exp_q.push_back(model_stream());
      if (rdy) begin
        for (int k = 0; k < LN; k++) model_lane[k] = lfsr_next(model_lane[k]);
        beats++;
      end
      finished = stp || (len != 0 && rdy && beats == len);
      tick();
    end
    i_ready     = 1'b0;
    i_stop      = 1'b0;
    i_seed_load = 1'b0;
    i_start     = 1'b0;
    if (!finished) begin
      failNote("burst_timeout", "actual=no burst end within 400 cycles required=burst end");
      resetMidBurst();
      return;
    end
    done_q.push_back(beats);
    checkOutput("done_pulse", o_done, 1);
    checkOutput("done_valid_low", o_valid, 0);
    checkOutput("done_busy_low", o_busy, 0);
    tick();
    checkOutput("idle_done_low", o_done, 0);
    checkOutput("idle_valid_low", o_valid, 0);
  endtask

  // Monitor: pop an expected beat for every cycle the DUT presents data,
  // and tally accepts against the expected burst length at o_done.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checkOutput("loop_quiet", o_lfsr_loop, 0);
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          failNote("unexpected_beat", "actual=o_valid high required=no beat");
        end else begin
          checkOutput("stream", o_stream, exp_q.pop_front());
          checkOutput("busy_in_run", o_busy, 1);
        end
        if (i_ready) mon_beats++;
      end
      if (o_done) begin
        if (done_q.size() == 0)
          failNote("unexpected_done", "actual=o_done high required=no done");
        else
          checkOutput("done_beats", mon_beats, done_q.pop_front());
        mon_beats = 0;
      end
    end
  end

  initial begin
    logic [SW-1:0] seeds;
    rst         = 1'b1;
    i_seed_load = 1'b0;
    i_seed_data = '0;
    i_start     = 1'b0;
    i_burst_len = '0;
    i_stop      = 1'b0;
    i_ready     = 1'b0;
    modelReset();
    #12;
    checkOutput("reset_stream", o_stream, reset_stream());
    checkOutput("reset_valid", o_valid, 0);
    checkOutput("reset_busy", o_busy, 0);
    checkOutput("reset_done", o_done, 0);
    checkOutput("reset_loop", o_lfsr_loop, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Seed lane0 = 1 with a simultaneous start, which must be ignored.
    seeds = {$urandom, $urandom, $urandom, 32'h1};
    loadSeeds(seeds, 1'b1);
    tick();
    checkOutput("start_ignored_on_load", o_valid, 0);
    applyStimulus(3, -1, -1, -1, 1'b1, 1'b0);

    // Zero seed substitution and all-ones pass-through.
    seeds = {$urandom, $urandom, 32'hFFFF_FFFF, 32'h0};
    loadSeeds(seeds, 1'b0);
    checkOutput("zero_seed_lane0", o_stream[LW-1:0], 1);
    checkOutput("ones_seed_lane1", o_stream[2*LW-1:LW], 32'hFFFF_FFFF);

    // Random bursts with ready back-pressure and ignored start/seed noise.
    for (int b = 0; b < 6; b++)
      applyStimulus($urandom_range(1, 15), -1, -1, -1, 1'b0, 1'b1);

    // Free run stopped after 10 accepts with a beat in the stop cycle.
    applyStimulus(0, 10, 1, -1, 1'b1, 1'b0);
    // Free run across the counter wrap, stopped without a beat.
    applyStimulus(0, 20, 0, -1, 1'b0, 1'b0);
    // Early stop of a counted burst.
    applyStimulus(12, 4, -1, -1, 1'b0, 1'b0);

    // Reset mid-burst, then resume from the reset values.
    applyStimulus(0, -1, -1, 5, 1'b0, 1'b0);
    applyStimulus(4, -1, -1, -1, 1'b1, 1'b0);

    for (int b = 0; b < 3; b++) begin
      loadSeeds({$urandom, $urandom, $urandom, $urandom}, 1'b0);
      applyStimulus($urandom_range(1, 15), -1, -1, -1, 1'b0, 1'b1);
    end

    tick();
    tick();
    checkOutput("exp_queue_drained", exp_q.size(), 0);
    checkOutput("done_queue_drained", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
